// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO: DEPTH usable entries, occupancy count,
// almost-full/almost-empty thresholds and one-cycle overflow/underflow pulses.
module sync_fifo_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       w_en,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       r_en,
    output logic [DATA_W-1:0]          data_out,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0]     w_ptr_reg;
    logic [AW-1:0]     r_ptr_reg;
    logic [CW-1:0]     count_reg;
    logic [CW-1:0]     count_next;
    logic [DATA_W-1:0] data_out_reg;
    logic              overflow_reg;
    logic              underflow_reg;

    logic full_int;
    logic empty_int;
    logic wr_ok;
    logic rd_ok;

    // Status flags decode the registered count only, so they never glitch.
    assign full_int  = (count_reg == DEPTH_C);
    assign empty_int = (count_reg == '0);
    assign wr_ok     = w_en & ~full_int;
    assign rd_ok     = r_en & ~empty_int;

    always_comb begin
        count_next = count_reg;
        if (wr_ok && !rd_ok) begin
            count_next = count_reg + 1'b1;
        end else if (rd_ok && !wr_ok) begin
            count_next = count_reg - 1'b1;
        end
    end

    // Storage has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[w_ptr_reg] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_ptr_reg     <= '0;
            r_ptr_reg     <= '0;
            count_reg     <= '0;
            data_out_reg  <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (wr_ok) begin
                w_ptr_reg <= w_ptr_reg + 1'b1;
            end
            if (rd_ok) begin
                r_ptr_reg    <= r_ptr_reg + 1'b1;
                data_out_reg <= mem[r_ptr_reg];
            end
            count_reg     <= count_next;
            overflow_reg  <= w_en & full_int;
            underflow_reg <= r_en & empty_int;
        end
    end

    assign data_out     = data_out_reg;
    assign count        = count_reg;
    assign full         = full_int;
    assign empty        = empty_int;
    assign almost_full  = (count_reg >= AF_C);
    assign almost_empty = (count_reg <= AE_C);
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised scoreboard bench for sync_fifo_param against a queue-based model.
module tb_sync_fifo_param;

    localparam int DATA_W   = 8;
    localparam int DEPTH    = 8;
    localparam int AF_LEVEL = 6;
    localparam int AE_LEVEL = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              w_en = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              r_en = 1'b0;
    logic [DATA_W-1:0] data_out;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [3:0]        count;
    logic              overflow;
    logic              underflow;

    sync_fifo_param #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL), .AE_LEVEL(AE_LEVEL)
    ) dut (
        .clk(clk), .reset(reset), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .data_out(data_out), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int  cnt;
        int  dout;
        bit  ovf;
        bit  udf;
        bit  rd;
    } exp_t;

    exp_t            exp_q[$];
    logic [7:0]      model_q[$];
    int              model_dout = 0;
    int              total = 0;
    int              bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    // One cycle of stimulus; the model decides acceptance from the pre-edge occupancy.
    task automatic step(input logic w, input logic [7:0] d, input logic r);
        exp_t e;
        int   sz;
        @(negedge clk);
        w_en = w;
        data_in = d;
        r_en = r;
        sz = model_q.size();
        e.ovf = w && (sz == DEPTH);
        e.udf = r && (sz == 0);
        e.rd  = r && (sz > 0);
        if (e.rd) model_dout = model_q.pop_front();
        if (w && sz < DEPTH) model_q.push_back(d);
        e.cnt  = model_q.size();
        e.dout = model_dout;
        exp_q.push_back(e);
    endtask

    // Monitor: one expected record per stimulus cycle, checked just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("count", int'(count), e.cnt);
                chk("data_out", int'(data_out), e.dout);
                chk("full", int'(full), int'(e.cnt == DEPTH));
                chk("empty", int'(empty), int'(e.cnt == 0));
                chk("almost_full", int'(almost_full), int'(e.cnt >= AF_LEVEL));
                chk("almost_empty", int'(almost_empty), int'(e.cnt <= AE_LEVEL));
                chk("overflow", int'(overflow), int'(e.ovf));
                chk("underflow", int'(underflow), int'(e.udf));
                if (e.rd)
                    $display("rd data=0x%02h count=%0d t=%0t", data_out, count, $time);
            end
        end
    end

    task automatic check_reset_state(input string tag);
        chk({tag, "_count"}, int'(count), 0);
        chk({tag, "_empty"}, int'(empty), 1);
        chk({tag, "_full"}, int'(full), 0);
        chk({tag, "_ae"}, int'(almost_empty), 1);
        chk({tag, "_af"}, int'(almost_full), 0);
        chk({tag, "_dout"}, int'(data_out), 0);
        chk({tag, "_ovf"}, int'(overflow), 0);
        chk({tag, "_udf"}, int'(underflow), 0);
    endtask

    initial begin
        int sz;
        logic w, r;

        #12;
        check_reset_state("por");
        @(negedge clk);
        reset = 1'b1;

        // Fill with 0x11..0x88, then attempt a write while full.
        for (int i = 1; i <= 8; i++) step(1'b1, 8'(i * 8'h11), 1'b0);
        step(1'b1, 8'h99, 1'b0);
        step(1'b0, 8'h00, 1'b0);

        // Drain everything, then one read too many.
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        // Pointer wrap with occupancy kept in 3..5.
        for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        for (int i = 0; i < 20; i++) begin
            sz = model_q.size();
            w = (sz < 5) ? 1'($urandom % 2) : 1'b0;
            r = (sz > 3 || w) ? 1'($urandom % 2) : 1'b0;
            step(w, 8'($urandom_range(0, 255)), r);
        end

        // Simultaneous requests at count 4, 0 and DEPTH.
        while (model_q.size() > 4) step(1'b0, 8'h00, 1'b1);
        while (model_q.size() < 4) step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        step(1'b1, 8'h3C, 1'b1);
        while (model_q.size() > 0) step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h5A, 1'b1);
        while (model_q.size() < DEPTH) step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        step(1'b1, 8'hC3, 1'b1);

        // Random traffic.
        for (int i = 0; i < 300; i++)
            step(1'($urandom % 2), 8'($urandom_range(0, 255)), 1'($urandom % 2));

        // Asynchronous reset between edges at count 5.
        while (model_q.size() > 5) step(1'b0, 8'h00, 1'b1);
        while (model_q.size() < 5) step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        @(posedge clk);
        #3;
        w_en = 1'b0;
        r_en = 1'b0;
        reset = 1'b0;
        #1;
        check_reset_state("arst");
        model_q.delete();
        model_dout = 0;
        @(negedge clk);
        reset = 1'b1;
        step(1'b1, 8'hA5, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
